alu_flag_stage: RTL and testbench

ALU_FLAG_STAGE -- requirements
Module: alu_flag_stage

---
 rtl/alu_flag_stage_if.sv | 37 +++
 rtl/alu_flag_stage.sv | 125 ++++++++++++
 tb/tb_alu_flag_stage.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_flag_stage_if.sv
// Handshake/data bundle for alu_flag_stage: subtractor beat in, buffered result out.
// StickyOvf/ClrOvf exist only when STICKY_OVF_EN is defined.
interface alu_flag_stage_if;
    logic        InValid;
    logic        InReady;
    logic [31:0] In;
    logic [3:0]  InFlags;
    logic        S;
    logic [2:0]  Cond;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] Out;
    logic        Taken;
    logic [3:0]  FlagReg;
`ifdef STICKY_OVF_EN
    logic        ClrOvf;
    logic        StickyOvf;
`endif

    modport master (
        output InValid, In, InFlags, S, Cond, OutReady,
`ifdef STICKY_OVF_EN
        output ClrOvf,
        input  StickyOvf,
`endif
        input  InReady, OutValid, Out, Taken, FlagReg
    );

    modport slave (
        input  InValid, In, InFlags, S, Cond, OutReady,
`ifdef STICKY_OVF_EN
        input  ClrOvf,
        output StickyOvf,
`endif
        output InReady, OutValid, Out, Taken, FlagReg
    );
endinterface

// File: rtl/alu_flag_stage.sv
// Flag/condition stage: latches subtractor flags, evaluates Cond, buffers {In, Taken} in a 2-entry FIFO.
// Optional sticky overflow flag enabled by defining STICKY_OVF_EN.
module alu_flag_stage #(
    parameter int DEPTH = 2
) (
    input logic            clk,
    input logic            rst_n,
    alu_flag_stage_if.slave bus
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [32:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_q;
    logic        taken_q;
    logic [3:0]  flag_reg;

    logic        accept;
    logic        retire;
    logic [3:0]  eff;
    logic        taken_new;
    logic [1:0]  count_nxt;
    logic        rd_ptr_nxt;
    logic [32:0] head_nxt;

    assign accept = bus.InValid & in_ready;
    assign retire = out_valid & bus.OutReady;

    // Select on S first so an X on InFlags with S=0 never propagates.
    always_comb begin
        eff = flag_reg;
        if (bus.S) eff = bus.InFlags;
    end

    always_comb begin
        taken_new = 1'b0;
        case (bus.Cond)
            3'b000: taken_new = 1'b1;
            3'b001: taken_new = eff[2];
            3'b010: taken_new = ~eff[2];
            3'b011: taken_new = eff[3];
            3'b100: taken_new = ~eff[3];
            3'b101: taken_new = eff[3] | eff[2];
            3'b110: taken_new = ~eff[3] & ~eff[2];
            3'b111: taken_new = eff[0];
            default: taken_new = 1'b0;
        endcase
    end

    always_comb begin
        count_nxt = count;
        case ({accept, retire})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    assign rd_ptr_nxt = rd_ptr ^ retire;

    // Head register is refreshed from the slot the read pointer will point to,
    // bypassing the write when that slot is being filled on this same edge.
    always_comb begin
        head_nxt = {out_q, taken_q};
        if (count_nxt != 2'd0) begin
            if (accept && (wr_ptr == rd_ptr_nxt))
                head_nxt = {bus.In, taken_new};
            else
                head_nxt = mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_q     <= '0;
            taken_q   <= 1'b0;
            flag_reg  <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= {bus.In, taken_new};
                wr_ptr      <= ~wr_ptr;
            end
            if (accept && bus.S) flag_reg <= bus.InFlags;
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            in_ready  <= count_nxt < FULL;
            out_valid <= count_nxt != 2'd0;
            out_q     <= head_nxt[32:1];
            taken_q   <= head_nxt[0];
        end
    end

    assign bus.InReady  = in_ready;
    assign bus.OutValid = out_valid;
    assign bus.Out      = out_q;
    assign bus.Taken    = taken_q;
    assign bus.FlagReg  = flag_reg;

`ifdef STICKY_OVF_EN
    logic sticky_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n)
            sticky_ovf <= 1'b0;
        else if (accept && bus.S && bus.InFlags[0])
            sticky_ovf <= 1'b1;
        else if (bus.ClrOvf)
            sticky_ovf <= 1'b0;
    end

    assign bus.StickyOvf = sticky_ovf;
`endif

endmodule

// File: tb/tb_alu_flag_stage.sv
// Directed self-checking bench for alu_flag_stage; sticky checks run when STICKY_OVF_EN is defined.
module tb_alu_flag_stage;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    alu_flag_stage_if bus ();

    alu_flag_stage #(.DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] val;
        logic        s;
        logic [3:0]  fl;
        logic [2:0]  cond;
        logic        tk;
        logic [3:0]  fr;
    } step_t;

    // Each step retires the previous head and pushes a new one; the new beat becomes head.
    step_t steps [9] = '{
        '{32'd8,  1'b0, 4'bxxxx, 3'b100, 1'b0, 4'b1000},
        '{32'd9,  1'b1, 4'b0000, 3'b010, 1'b1, 4'b0000},
        '{32'd10, 1'b1, 4'b0100, 3'b101, 1'b1, 4'b0100},
        '{32'd11, 1'b0, 4'bxxxx, 3'b110, 1'b0, 4'b0100},
        '{32'd12, 1'b1, 4'b0000, 3'b110, 1'b1, 4'b0000},
        '{32'd13, 1'b1, 4'b0001, 3'b111, 1'b1, 4'b0001},
        '{32'd14, 1'b0, 4'bxxxx, 3'b111, 1'b1, 4'b0001},
        '{32'd15, 1'b1, 4'b1000, 3'b101, 1'b1, 4'b1000},
        '{32'd16, 1'b1, 4'b0010, 3'b011, 1'b0, 4'b0010}
    };

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] val, input logic s, input logic [3:0] fl, input logic [2:0] cond);
        bus.InValid = 1'b1;
        bus.In      = val;
        bus.S       = s;
        bus.InFlags = fl;
        bus.Cond    = cond;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.InValid  = 1'b0;
        bus.In       = '0;
        bus.InFlags  = '0;
        bus.S        = 1'b0;
        bus.Cond     = '0;
        bus.OutReady = 1'b0;
`ifdef STICKY_OVF_EN
        bus.ClrOvf   = 1'b0;
`endif
        tick();
        tick();
        chk("rst_inready", 32'(bus.InReady), 32'd0);
        chk("rst_outvalid", 32'(bus.OutValid), 32'd0);
        chk("rst_flagreg", 32'(bus.FlagReg), 32'd0);
        chk("rst_out", bus.Out, 32'd0);
        chk("rst_taken", 32'(bus.Taken), 32'd0);
`ifdef STICKY_OVF_EN
        chk("rst_sticky", 32'(bus.StickyOvf), 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        chk("rel_inready", 32'(bus.InReady), 32'd1);
        chk("rel_outvalid", 32'(bus.OutValid), 32'd0);

        // First beat: EQ set, condition EQ.
        push(32'd5, 1'b1, 4'b0100, 3'b001);
        tick();
        bus.InValid = 1'b0;
        chk("b1_outvalid", 32'(bus.OutValid), 32'd1);
        chk("b1_out", bus.Out, 32'd5);
        chk("b1_taken", 32'(bus.Taken), 32'd1);
        chk("b1_flagreg", 32'(bus.FlagReg), 32'h4);
        chk("b1_inready", 32'(bus.InReady), 32'd1);
        bus.OutReady = 1'b1;
        tick();
        bus.OutReady = 1'b0;
        chk("drain_outvalid", 32'(bus.OutValid), 32'd0);
        chk("drain_hold_out", bus.Out, 32'd5);

        // Load FlagReg=1000, then an S=0 beat with X flags evaluates LT from FlagReg.
        push(32'd6, 1'b1, 4'b1000, 3'b000);
        tick();
        chk("b2_out", bus.Out, 32'd6);
        chk("b2_flagreg", 32'(bus.FlagReg), 32'h8);
        push(32'd7, 1'b0, 4'bxxxx, 3'b011);
        bus.OutReady = 1'b1;
        tick();
        chk("x_outvalid", 32'(bus.OutValid), 32'd1);
        chk("x_out", bus.Out, 32'd7);
        chk("x_taken", 32'(bus.Taken), 32'd1);
        chk("x_flagreg", 32'(bus.FlagReg), 32'h8);
        chk("x_noxout", 32'($isunknown({bus.Out, bus.Taken, bus.FlagReg, bus.InReady, bus.OutValid})), 32'd0);

        foreach (steps[k]) begin
            push(steps[k].val, steps[k].s, steps[k].fl, steps[k].cond);
            tick();
            chk($sformatf("cond%0d_out", k), bus.Out, steps[k].val);
            chk($sformatf("cond%0d_taken", k), 32'(bus.Taken), 32'(steps[k].tk));
            chk($sformatf("cond%0d_flagreg", k), 32'(bus.FlagReg), 32'(steps[k].fr));
        end
        bus.InValid = 1'b0;
        tick();
        bus.OutReady = 1'b0;
        chk("cond_drain", 32'(bus.OutValid), 32'd0);

        // Backpressure: A and B fill the buffer, C waits.
        push(32'hA, 1'b0, 4'bxxxx, 3'b000);
        tick();
        chk("bp_a_inready", 32'(bus.InReady), 32'd1);
        push(32'hB, 1'b0, 4'bxxxx, 3'b000);
        tick();
        chk("bp_full_inready", 32'(bus.InReady), 32'd0);
        chk("bp_head_a", bus.Out, 32'hA);
        push(32'hC, 1'b0, 4'bxxxx, 3'b000);
        tick();
        chk("bp_stall_inready", 32'(bus.InReady), 32'd0);
        chk("bp_stall_out", bus.Out, 32'hA);
        bus.OutReady = 1'b1;
        tick();
        chk("bp_head_b", bus.Out, 32'hB);
        chk("bp_reopen", 32'(bus.InReady), 32'd1);
        tick();
        bus.InValid = 1'b0;
        chk("bp_head_c", bus.Out, 32'hC);
        chk("bp_c_valid", 32'(bus.OutValid), 32'd1);
        tick();
        bus.OutReady = 1'b0;
        chk("bp_empty", 32'(bus.OutValid), 32'd0);

        // Streaming from count=1: ten beats, one per cycle.
        push(32'd0, 1'b0, 4'bxxxx, 3'b000);
        tick();
        bus.OutReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 9) bus.In = 32'(i + 1);
            else bus.InValid = 1'b0;
            chk($sformatf("stream%0d_valid", i), 32'(bus.OutValid), 32'd1);
            chk($sformatf("stream%0d_out", i), bus.Out, 32'(i));
            tick();
        end
        bus.OutReady = 1'b0;
        chk("stream_end", 32'(bus.OutValid), 32'd0);

        // Reset with two entries buffered and a beat in flight.
        push(32'h20, 1'b1, 4'b0101, 3'b000);
        tick();
        push(32'h21, 1'b1, 4'b0101, 3'b000);
        tick();
        chk("prerst_flagreg", 32'(bus.FlagReg), 32'h5);
        push(32'h22, 1'b1, 4'b1111, 3'b000);
        rst_n = 1'b0;
        tick();
        bus.InValid = 1'b0;
        chk("mrst_outvalid", 32'(bus.OutValid), 32'd0);
        chk("mrst_flagreg", 32'(bus.FlagReg), 32'h0);
        chk("mrst_inready", 32'(bus.InReady), 32'd0);
        chk("mrst_out", bus.Out, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("mrel_inready", 32'(bus.InReady), 32'd1);
        chk("mrel_outvalid", 32'(bus.OutValid), 32'd0);

`ifdef STICKY_OVF_EN
        bus.OutReady = 1'b1;
        push(32'h30, 1'b1, 4'b0001, 3'b000);
        tick();
        chk("sticky_set", 32'(bus.StickyOvf), 32'd1);
        push(32'h31, 1'b1, 4'b0001, 3'b000);
        bus.ClrOvf = 1'b1;
        tick();
        chk("sticky_set_wins", 32'(bus.StickyOvf), 32'd1);
        bus.InValid = 1'b0;
        tick();
        chk("sticky_clear", 32'(bus.StickyOvf), 32'd0);
        bus.ClrOvf = 1'b0;
        push(32'h32, 1'b0, 4'bxxxx, 3'b000);
        tick();
        bus.InValid = 1'b0;
        chk("sticky_s0_noset", 32'(bus.StickyOvf), 32'd0);
        bus.OutReady = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
